// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO between the command/loopback producers and the UART transmitter
//
// Single-clock synchronous FIFO built on an inferred RAM. The read port is registered,
// so dout changes on the edge that accepts a read. It is not first-word-fall-through.
// Usable depth is 2**ADDR_WIDTH-1 words.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset (stored data discarded, RAM not cleared)
//   wrEn, din    write request and data; the word is captured when the write is accepted
//   readEn       read request from the transmitter
//   dout         registered read data; holds its value when no read is accepted
//   full, empty  registered occupancy flags, exact on the cycle after each access
//   rdDataCount  registered number of stored words
//   overflow     write rejected because the FIFO was full
//   underflow    read rejected because the FIFO was empty
//
// Build option:
//   TX_FIFO_STICKY_ERR_EN  defined   : overflow/underflow stay set until rst
//                          undefined : overflow/underflow are one-cycle pulses

module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  readEn,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] rdDataCount,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = {ADDR_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  udf_evt;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    // Requests in the reset cycle are ignored.
    always_comb begin
        rd_acc  = readEn & ~empty_q & ~rst;
        wr_acc  = wrEn & (~full_q | rd_acc) & ~rst;
        ovf_evt = wrEn & full_q & ~rd_acc;
        udf_evt = readEn & empty_q;
    end

    always_comb begin
        mem_rd_data = mem[rd_ptr_q];

        wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
        dout_d   = rd_acc ? mem_rd_data : dout_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - ONE;
        end

        // Flags come from the next count so they are registered yet exact.
        full_d  = (count_d == MAX_COUNT);
        empty_d = (count_d == '0);

`ifdef TX_FIFO_STICKY_ERR_EN
        overflow_d  = overflow_q | ovf_evt;
        underflow_d = underflow_q | udf_evt;
`else
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout        = dout_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign rdDataCount = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

`ifdef TX_FIFO_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn;
    logic [7:0] din;
    logic       readEn;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [9:0] rdDataCount;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] last_dout;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .din(din), .readEn(readEn),
        .dout(dout), .full(full), .empty(empty), .rdDataCount(rdDataCount),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_count"}, 32'(rdDataCount), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'h00);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_udf"}, 32'(underflow), 32'd0);
    endtask

    task automatic fill_and_overflow(input string tag);
        wrEn = 1'b1;
        for (int i = 0; i < 1023; i++) begin
            din = 8'(i);
            q.push_back(8'(i));
            cyc();
            if (i == 1021) begin
                chk({tag, "_count_1022"}, 32'(rdDataCount), 32'd1022);
                chk({tag, "_notfull_1022"}, 32'(full), 32'd0);
            end
        end
        wrEn = 1'b0;
        chk({tag, "_full"}, 32'(full), 32'd1);
        chk({tag, "_count_full"}, 32'(rdDataCount), 32'd1023);
        chk({tag, "_no_ovf_yet"}, 32'(overflow), 32'd0);
        wrEn = 1'b1;
        din  = 8'hFF;
        cyc();
        wrEn = 1'b0;
        chk({tag, "_ovf_set"}, 32'(overflow), 32'd1);
        chk({tag, "_count_kept"}, 32'(rdDataCount), 32'd1023);
        chk({tag, "_full_kept"}, 32'(full), 32'd1);
        cyc();
        chk({tag, "_ovf_after"}, 32'(overflow), 32'(STICKY));
    endtask

    initial begin
        rst = 1'b1; wrEn = 1'b0; readEn = 1'b0; din = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        // 1. reset/idle state
        chk_idle_reset("reset");

        // 2. three writes then three reads
        wrEn = 1'b1;
        din = 8'h41; cyc();
        chk("t2_count1", 32'(rdDataCount), 32'd1);
        chk("t2_empty_clr", 32'(empty), 32'd0);
        din = 8'h42; cyc();
        din = 8'h43; cyc();
        wrEn = 1'b0;
        chk("t2_count3", 32'(rdDataCount), 32'd3);
        readEn = 1'b1;
        cyc();
        chk("t2_dout41", 32'(dout), 32'h41);
        chk("t2_count2", 32'(rdDataCount), 32'd2);
        cyc();
        chk("t2_dout42", 32'(dout), 32'h42);
        cyc();
        readEn = 1'b0;
        chk("t2_dout43", 32'(dout), 32'h43);
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_count0", 32'(rdDataCount), 32'd0);
        cyc();
        chk("t2_dout_hold", 32'(dout), 32'h43);

        // 3. fill to 1023, rejected extra write
        fill_and_overflow("t3");

        // 4. full FIFO with simultaneous write and read for 10 cycles
        wrEn = 1'b1; readEn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 8'h80 + 8'(k);
            exp_b = q.pop_front();
            q.push_back(8'h80 + 8'(k));
            cyc();
            chk($sformatf("t4_dout_%0d", k), 32'(dout), 32'(exp_b));
            chk($sformatf("t4_full_%0d", k), 32'(full), 32'd1);
            chk($sformatf("t4_ovf_%0d", k), 32'(overflow), 32'(STICKY));
        end
        wrEn = 1'b0;
        // drain everything; the rejected 0xFF must never show up out of order
        for (int k = 0; k < 1023; k++) begin
            exp_b = q.pop_front();
            cyc();
            chk($sformatf("t4_drain_%0d", k), 32'(dout), 32'(exp_b));
        end
        readEn = 1'b0;
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_count0", 32'(rdDataCount), 32'd0);
        chk("t4_udf_none", 32'(underflow), 32'd0);
        last_dout = exp_b;

        // 5. empty FIFO with simultaneous write and read
        wrEn = 1'b1; readEn = 1'b1; din = 8'h5A;
        cyc();
        wrEn = 1'b0;
        chk("t5_udf", 32'(underflow), 32'd1);
        chk("t5_count1", 32'(rdDataCount), 32'd1);
        chk("t5_dout_hold", 32'(dout), 32'(last_dout));
        cyc();
        readEn = 1'b0;
        chk("t5_dout5a", 32'(dout), 32'h5A);
        chk("t5_udf_after", 32'(underflow), 32'(STICKY));
        chk("t5_count0", 32'(rdDataCount), 32'd0);

        // 6. reset with 5 words stored and readEn/wrEn high
        wrEn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            din = 8'(k);
            cyc();
        end
        chk("t6_count5", 32'(rdDataCount), 32'd5);
        rst = 1'b1; readEn = 1'b1; din = 8'h77;
        cyc();
        rst = 1'b0; readEn = 1'b0; wrEn = 1'b0;
        chk_idle_reset("t6");
        cyc();
        chk("t6_count_idle", 32'(rdDataCount), 32'd0);
        chk("t6_empty_idle", 32'(empty), 32'd1);

        // repeat scenario 3 after reset, then verify order from the new start
        q.delete();
        fill_and_overflow("t6r");
        readEn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_b = q.pop_front();
            cyc();
            chk($sformatf("t6r_dout_%0d", k), 32'(dout), 32'(exp_b));
        end
        readEn = 1'b0;
        chk("t6r_count", 32'(rdDataCount), 32'd1019);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
